// File: rtl/program_loader.sv
// Packs {acc_select, opcode, immediate} beats into 8-bit words and writes them to program RAM from address 0.
// Write latency 1 cycle; in_ready is decoded from registered state, so a held beat waits until LOAD.
module program_loader #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_acc_select,
    input  logic [2:0]            in_opcode,
    input  logic [3:0]            in_immediate,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic [7:0]            checksum,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_load_count;
    logic [7:0]            r_checksum;
    logic                  r_overflow;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;

    logic                  w_accept;
    logic                  w_full;
    logic                  w_clear;
    logic [7:0]            w_word;

    assign w_accept = in_valid && (r_state == S_LOAD);
    // The pointer sits at DEPTH-1 exactly when the current beat fills memory.
    assign w_full   = &r_wr_ptr;
    assign w_clear  = start && (r_state != S_LOAD);
    assign w_word   = {in_acc_select, in_opcode, in_immediate};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && (in_last || w_full)) w_next = S_DONE;
            S_DONE:  w_next = start ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
            r_checksum   <= '0;
            r_overflow   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= w_accept;
            if (w_accept) begin
                r_mem_addr   <= r_wr_ptr;
                r_mem_wdata  <= w_word;
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_load_count <= r_load_count + 1'b1;
                r_checksum   <= r_checksum ^ w_word;
                if (w_full && !in_last) r_overflow <= 1'b1;
            end
            if (w_clear) begin
                r_wr_ptr     <= '0;
                r_load_count <= '0;
                r_checksum   <= '0;
                r_overflow   <= 1'b0;
            end
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign busy       = in_ready;
    assign done       = (r_state == S_DONE);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign load_count = r_load_count;
    assign checksum   = r_checksum;
    assign overflow   = r_overflow;

endmodule
